image_eth_deformatter: RTL and testbench
========================================

IMAGE_ETH_DEFORMATTER -- requirements
Module: image_eth_deformatter

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (range 1..4095).
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame (range 1..65535).
REQ-003 clk_pixel  input  1  pixel clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 fifo_empty  input  1  RX byte FIFO empty flag.
REQ-006 read_data  input  8  FIFO output byte, valid one cycle after read_req.
REQ-007 read_req  output  1  FIFO read strobe.
REQ-008 vsync  output  1  frame active, high for the whole frame.
REQ-009 hsync  output  1  line active, high from the first through the last pixel of a line.
REQ-010 valid  output  1  pixel_data qualifier.
REQ-011 pixel_data  output  8  recovered pixel.
REQ-012 line_count  output  16  line number of the current or last line.
REQ-013 seq_err  output  1  one-cycle pulse on a rejected line.

Function
REQ-014 Stream format per line SHALL be: 0xA5, 0x5A, line number MSB, line number LSB, then IMG_WIDTH pixel bytes.
REQ-015 read_req SHALL be combinational !fifo_empty && rst_n; no downstream backpressure exists.
REQ-016 byte_valid SHALL be read_req registered once; the FSM advances only on byte_valid cycles.
REQ-017 FSM states SHALL be HUNT_A5, HUNT_5A, LN_HI, LN_LO, PIXELS.
REQ-018 HUNT_A5: byte 0xA5 -> HUNT_5A; any other byte stays in HUNT_A5.
REQ-019 HUNT_5A: 0x5A -> LN_HI; 0xA5 stays in HUNT_5A; any other byte -> HUNT_A5.
REQ-020 LN_HI SHALL latch the MSB and go to LN_LO.
REQ-021 LN_LO: line number >= IMG_HEIGHT SHALL pulse seq_err, drop vsync, and go to HUNT_A5.
REQ-022 LN_LO otherwise SHALL load line_count, clear the 12-bit pixel counter, and go to PIXELS.
REQ-023 LN_LO with line number 0 while vsync=1 SHALL drive vsync low for exactly one cycle (frame restart).
REQ-024 PIXELS: each byte SHALL produce, on the next cycle, pixel_data=byte, valid=1, hsync=1.
REQ-025 The last pixel (counter = IMG_WIDTH-1) SHALL return the FSM to HUNT_A5.
REQ-026 Latency SHALL be exactly 1 cycle from a byte_valid pixel byte to valid.
REQ-027 FIFO underflow inside PIXELS SHALL hold hsync=1 and valid=0 and retain pixel_data; the line then resumes.
REQ-028 The cycle after a line's last pixel SHALL have hsync=0 and valid=0.
REQ-029 vsync SHALL rise together with the first pixel of line 0.
REQ-030 vsync SHALL fall on the cycle after the last pixel of line IMG_HEIGHT-1.
REQ-031 Lines other than line 0 received while vsync=0 SHALL be output with hsync and valid but with vsync=0.

Reset
REQ-032 rst_n=0 SHALL set the FSM to HUNT_A5 and clear byte_valid and the counters.
REQ-033 rst_n=0 SHALL force vsync, hsync, valid, pixel_data, line_count and seq_err to 0, and read_req to 0.
REQ-034 Reset mid-line SHALL discard the partial line; after release the block rehunts for 0xA5.

Configuration
REQ-035 Macro DEFORMATTER_SEQ_CHECK_EN defined: a nonzero line number not equal to previous line_count+1 SHALL pulse seq_err, drop vsync, and go to HUNT_A5.
REQ-036 Macro DEFORMATTER_SEQ_CHECK_EN undefined: line number sequence SHALL NOT be checked; only REQ-021 rejection applies.

Verification
REQ-037 IMG_WIDTH=4, IMG_HEIGHT=2, stream A5 5A 00 00 10 11 12 13 A5 5A 00 01 20 21 22 23 -> valid pixels 10..13 then 20..23; vsync high from pixel 10 through pixel 23, low the next cycle; hsync low between lines; line_count 0 then 1.
REQ-038 Garbage prefix 33 A5 A5 5A 00 00 followed by 4 pixels -> sync acquired, all 4 pixels output, seq_err never asserted.
REQ-039 fifo_empty=1 for 3 cycles after the 2nd pixel of a line -> hsync stays 1, valid=0 for 3 cycles, the remaining 2 pixels follow unchanged.
REQ-040 Header A5 5A 00 05 with IMG_HEIGHT=2 -> seq_err one-cycle pulse, the 4 following bytes are not output as pixels.
REQ-041 With DEFORMATTER_SEQ_CHECK_EN: lines 0 then 0-repeated-as-2 (header 00 02, IMG_HEIGHT=4) -> seq_err pulse and vsync=0; without the macro the line is output.
REQ-042 rst_n=0 for 2 cycles after the 2nd pixel -> all outputs 0; a subsequent full line 0 is recovered correctly.

Source files
------------

// File: rtl/image_eth_deformatter.sv
// image_eth_deformatter: recovers pixel lines from an Ethernet RX byte FIFO stream.
// Line format: A5 5A line_hi line_lo, then IMG_WIDTH pixel bytes.
// Optional build macro DEFORMATTER_SEQ_CHECK_EN also rejects out-of-sequence nonzero line numbers.
// Ports: clk_pixel, rst_n (sync, active-low) | fifo_empty, read_data[7:0] in | read_req out |
//        vsync, hsync, valid, pixel_data[7:0], line_count[15:0], seq_err out.
module image_eth_deformatter #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic        clk_pixel,
   input  logic        rst_n,
   input  logic        fifo_empty,
   input  logic [7:0]  read_data,
   output logic        read_req,
   output logic        vsync,
   output logic        hsync,
   output logic        valid,
   output logic [7:0]  pixel_data,
   output logic [15:0] line_count,
   output logic        seq_err
);
   localparam logic [11:0] LAST_PX = 12'(IMG_WIDTH - 1);
   localparam logic [15:0] LAST_LN = 16'(IMG_HEIGHT - 1);
   typedef enum logic [2:0] {HUNT_A5, HUNT_5A, LN_HI, LN_LO, PIXELS} state_t;
   state_t      state;
   logic        byte_valid;
   logic        sof_pending;
   logic        eof_pending;
   logic [7:0]  ln_hi;
   logic [11:0] px_cnt;
   logic [15:0] ln;
   logic        bad_ln;
   assign read_req = !fifo_empty && rst_n;
   assign ln       = {ln_hi, read_data};
`ifdef DEFORMATTER_SEQ_CHECK_EN
   assign bad_ln = ln > LAST_LN || (ln != '0 && ln != line_count + 16'd1);
`else
   assign bad_ln = ln > LAST_LN;
`endif
   // sof_pending: a line 0 header was accepted, vsync rises with its first pixel.
   // eof_pending: the last pixel of the last line was just emitted, vsync falls next cycle.
   always_ff @(posedge clk_pixel) begin
      if (!rst_n) begin
         state       <= HUNT_A5;
         byte_valid  <= 1'b0;
         sof_pending <= 1'b0;
         eof_pending <= 1'b0;
         ln_hi       <= '0;
         px_cnt      <= '0;
         vsync       <= 1'b0;
         hsync       <= 1'b0;
         valid       <= 1'b0;
         pixel_data  <= '0;
         line_count  <= '0;
         seq_err     <= 1'b0;
      end else begin
         byte_valid  <= read_req;
         seq_err     <= 1'b0;
         valid       <= 1'b0;
         eof_pending <= 1'b0;
         if (eof_pending) vsync <= 1'b0;
         if (byte_valid && state == PIXELS) begin
            valid       <= 1'b1;
            hsync       <= 1'b1;
            pixel_data  <= read_data;
            px_cnt      <= px_cnt + 12'd1;
            sof_pending <= 1'b0;
            if (sof_pending) vsync <= 1'b1;
            if (px_cnt == LAST_PX) begin
               state       <= HUNT_A5;
               eof_pending <= line_count == LAST_LN;
            end
         end else begin
            // hsync survives FIFO underflow mid-line, drops once the line is over
            hsync <= hsync && state == PIXELS;
            if (byte_valid) begin
               case (state)
                  HUNT_A5: state <= read_data == 8'hA5 ? HUNT_5A : HUNT_A5;
                  HUNT_5A: state <= read_data == 8'h5A ? LN_HI : read_data == 8'hA5 ? HUNT_5A : HUNT_A5;
                  LN_HI: begin
                     ln_hi <= read_data;
                     state <= LN_LO;
                  end
                  LN_LO: begin
                     if (bad_ln) begin
                        seq_err     <= 1'b1;
                        vsync       <= 1'b0;
                        sof_pending <= 1'b0;
                        state       <= HUNT_A5;
                     end else begin
                        line_count  <= ln;
                        px_cnt      <= '0;
                        sof_pending <= ln == '0;
                        if (ln == '0) vsync <= 1'b0;
                        state       <= PIXELS;
                     end
                  end
                  default: state <= HUNT_A5;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_image_eth_deformatter.sv
// tb_image_eth_deformatter: directed vector table plus random stream against a protocol-level model.
module tb_image_eth_deformatter;
   localparam int W = 4;
   localparam int H = 4;
   logic        clk_pixel = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [7:0]  read_data = '0;
   logic        read_req, vsync, hsync, valid, seq_err;
   logic [7:0]  pixel_data;
   logic [15:0] line_count;
   int checks = 0;
   int fails = 0;

   image_eth_deformatter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk_pixel(clk_pixel), .rst_n(rst_n), .fifo_empty(fifo_empty), .read_data(read_data),
      .read_req(read_req), .vsync(vsync), .hsync(hsync), .valid(valid),
      .pixel_data(pixel_data), .line_count(line_count), .seq_err(seq_err)
   );

   always #5 clk_pixel = ~clk_pixel;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [7:0] q[$];
   logic       pend_v = 1'b0;
   logic [7:0] pend_b = '0;
   int         popped = 0;

   int          hdr = 0;
   int          px_left = 0;
   logic [7:0]  m_hi = '0;
   logic        m_sof = 1'b0, m_eof = 1'b0;
   logic        m_vs = 1'b0, m_hs = 1'b0, m_valid = 1'b0, m_se = 1'b0;
   logic [7:0]  m_pd = '0;
   logic [15:0] m_lc = '0;

   int         mon_serr, mon_gap, mon_zrun, mon_holes;
   logic       mon_seen, mon_vs_first;
   logic [7:0] mon_pix[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Protocol-level reference: header position counter, remaining-pixel count, frame flags.
   task automatic model_step(input logic rn, input logic bv, input logic [7:0] b);
      logic [15:0] ln;
      logic bad;
      if (!rn) begin
         hdr = 0; px_left = 0; m_sof = 0; m_eof = 0;
         {m_vs, m_hs, m_valid, m_se, m_pd, m_lc} = '0;
      end else begin
         m_se = 0;
         m_valid = 0;
         if (m_eof) m_vs = 0;
         m_eof = 0;
         if (bv && px_left > 0) begin
            m_pd = b; m_valid = 1; m_hs = 1;
            if (m_sof) m_vs = 1;
            m_sof = 0;
            px_left--;
            if (px_left == 0 && m_lc == 16'(H - 1)) m_eof = 1;
         end else begin
            if (px_left == 0) m_hs = 0;
            if (bv) begin
               if (hdr == 0) hdr = (b == 8'hA5) ? 1 : 0;
               else if (hdr == 1) hdr = (b == 8'h5A) ? 2 : (b == 8'hA5) ? 1 : 0;
               else if (hdr == 2) begin
                  m_hi = b; hdr = 3;
               end else begin
                  hdr = 0;
                  ln = {m_hi, b};
                  bad = int'(ln) >= H;
`ifdef DEFORMATTER_SEQ_CHECK_EN
                  bad = bad || (ln != 0 && ln != m_lc + 16'd1);
`endif
                  if (bad) begin
                     m_se = 1; m_vs = 0; m_sof = 0;
                  end else begin
                     m_lc = ln; px_left = W; m_sof = (ln == 0);
                     if (ln == 0) m_vs = 0;
                  end
               end
            end
         end
      end
   endtask

   // One clock: check outputs of the last edge, then drive inputs for the next edge.
   task automatic step(input logic rn, input logic stall);
      @(negedge clk_pixel);
      check("outputs", {vsync, hsync, valid, pixel_data, line_count, seq_err},
                       {m_vs, m_hs, m_valid, m_pd, m_lc, m_se});
      if (seq_err) mon_serr++;
      if (hsync && !valid) mon_gap++;
      if (mon_seen && !vsync) mon_zrun++;
      if (valid) begin
         if (!mon_seen) mon_vs_first = vsync;
         mon_seen = 1;
         mon_holes = mon_zrun;
         mon_pix.push_back(pixel_data);
      end
      rst_n = rn;
      fifo_empty = stall || q.size() == 0;
      read_data = pend_v ? pend_b : 8'($urandom);
      model_step(rn, pend_v, pend_b);
      pend_v = rn && !fifo_empty;
      if (pend_v) begin
         pend_b = q.pop_front();
         popped++;
      end
      #1 check("read_req", read_req, rn && !fifo_empty);
   endtask

   typedef struct packed {
      logic [63:0]      name;
      int               len;
      logic [0:31][7:0] data;
      int               stall_at;
      int               stall_len;
      int               rst_at;
      int               npix;
      logic [0:15][7:0] pix;
      int               serr;
      int               gap;
      int               holes;
      logic [15:0]      lc;
      logic             vs_first;
      logic             vs_end;
   } vec_t;
   vec_t vecs[9];

   initial begin
      vec_t t;
      int c, idle, st_left, rs_left, rp;
      logic sd, rn, stall;
      logic [15:0] ln;
      vecs[0] = '{"two_ln", 16, {128'hA55A0000_10111213_A55A0001_20212223, 128'h0}, -1, 0, -1, 8,
                  128'h10111213_20212223_00000000_00000000, 0, 0, 0, 16'd1, 1'b1, 1'b1};
      vecs[1] = '{"garbage", 10, {80'h33A5A55A000010111213, 176'h0}, -1, 0, -1, 4,
                  {32'h10111213, 96'h0}, 0, 0, 0, 16'd0, 1'b1, 1'b1};
      vecs[2] = '{"stall", 8, {64'hA55A0000_10111213, 192'h0}, 6, 3, -1, 4,
                  {32'h10111213, 96'h0}, 0, 3, 0, 16'd0, 1'b1, 1'b1};
      vecs[3] = '{"bad_ln", 8, {64'hA55A0005_40414243, 192'h0}, -1, 0, -1, 0,
                  128'h0, 1, 0, 0, 16'd0, 1'b0, 1'b0};
`ifdef DEFORMATTER_SEQ_CHECK_EN
      vecs[4] = '{"seq", 16, {128'hA55A0000_10111213_A55A0002_20212223, 128'h0}, -1, 0, -1, 4,
                  {32'h10111213, 96'h0}, 1, 0, 0, 16'd0, 1'b1, 1'b0};
`else
      vecs[4] = '{"seq", 16, {128'hA55A0000_10111213_A55A0002_20212223, 128'h0}, -1, 0, -1, 8,
                  128'h10111213_20212223_00000000_00000000, 0, 0, 0, 16'd2, 1'b1, 1'b1};
`endif
      vecs[5] = '{"rst_mid", 16, {128'hA55A0000_10111213_A55A0000_40414243, 128'h0}, -1, 0, 6, 6,
                  {48'h101140414243, 80'h0}, 0, 0, -1, 16'd0, 1'b1, 1'b1};
      vecs[6] = '{"frame", 32,
                  256'hA55A0000_10111213_A55A0001_20212223_A55A0002_30313233_A55A0003_40414243,
                  -1, 0, -1, 16, 128'h10111213_20212223_30313233_40414243, 0, 0, 0, 16'd3, 1'b1, 1'b0};
      vecs[7] = '{"restart", 16, {128'hA55A0000_10111213_A55A0000_20212223, 128'h0}, -1, 0, -1, 8,
                  128'h10111213_20212223_00000000_00000000, 0, 0, 1, 16'd0, 1'b1, 1'b1};
      vecs[8] = '{"no_vs", 8, {64'hA55A0001_50515253, 192'h0}, -1, 0, -1, 4,
                  {32'h50515253, 96'h0}, 0, 0, -1, 16'd1, 1'b0, 1'b0};
      model_step(1'b0, 1'b0, 8'h00);
      for (int v = 0; v < 9; v++) begin
         t = vecs[v];
         step(1'b0, 1'b1);
         step(1'b0, 1'b1);
         step(1'b1, 1'b1);
         check("reset_outs", {vsync, hsync, valid, pixel_data, line_count, seq_err, read_req}, 32'h0);
         mon_serr = 0; mon_gap = 0; mon_zrun = 0; mon_holes = 0; mon_seen = 0; mon_vs_first = 0;
         mon_pix.delete();
         for (int i = 0; i < t.len; i++) q.push_back(t.data[i]);
         popped = 0; st_left = 0; sd = 0; rp = 0; rs_left = 0; c = 0; idle = 0;
         while (c < 300 && idle < 5) begin
            rn = 1; stall = 0;
            if (!sd && popped == t.stall_at) begin
               sd = 1; st_left = t.stall_len;
            end
            if (st_left > 0) begin
               stall = 1; st_left--;
            end
            if (rp == 0 && popped == t.rst_at) rp = 1;
            if (rp == 1 && !pend_v) begin
               rp = 2; rs_left = 2;
            end
            if (rp == 2) begin
               rn = 0; rs_left--;
               if (rs_left == 0) rp = 3;
            end
            if (rp == 1) stall = 1;
            step(rn, stall);
            if (q.size() == 0 && !pend_v) idle++;
            c++;
         end
         check({"drain_", string'(t.name)}, q.size(), 0);
         check({"npix_", string'(t.name)}, mon_pix.size(), t.npix);
         for (int i = 0; i < t.npix && i < mon_pix.size(); i++)
            check({"pix_", string'(t.name)}, mon_pix[i], t.pix[i]);
         check({"seq_err_", string'(t.name)}, mon_serr, t.serr);
         check({"gap_", string'(t.name)}, mon_gap, t.gap);
         check({"line_count_", string'(t.name)}, line_count, t.lc);
         check({"vsync_end_", string'(t.name)}, vsync, t.vs_end);
         if (t.npix > 0) check({"vsync_first_", string'(t.name)}, mon_vs_first, t.vs_first);
         if (t.holes >= 0) check({"vsync_holes_", string'(t.name)}, mon_holes, t.holes);
      end
      for (int l = 0; l < 80; l++) begin
         if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
         q.push_back(8'hA5);
         q.push_back(8'h5A);
         ln = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 9)) : 16'(l % H);
         q.push_back(ln[15:8]);
         q.push_back(ln[7:0]);
         repeat (W) q.push_back(8'($urandom));
      end
      c = 0;
      while (c < 8000 && (q.size() != 0 || pend_v)) begin
         step($urandom_range(0, 199) != 0, $urandom_range(0, 4) == 0);
         c++;
      end
      check("random_drain", q.size(), 0);
      repeat (4) step(1'b1, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
